// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter sequencer.
package pc_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32'd32;
  localparam int unsigned DEFAULT_STEP   = 32'd4;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } pc_state_t;

  // Mask that clears the log2(step) low bits and every bit at or above addr_w.
  function automatic logic [63:0] align_mask(input int unsigned step, input int unsigned addr_w);
    logic [63:0] low_clear;
    logic [63:0] width_keep;
    low_clear  = ~(64'(step) - 64'd1);
    width_keep = (64'd1 << addr_w) - 64'd1;
    return low_clear & width_keep;
  endfunction

endpackage

// File: rtl/pc_step_adder.sv
// Parametrised pc incrementer: pc + STEP with the carry out discarded.
module pc_step_adder
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned STEP   = DEFAULT_STEP
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq
);

  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  // Modular add; the all-ones page wraps silently to zero.
  assign pc_next_seq = pc + STEP_W;

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch program-counter sequencer with stall freeze and a one-entry redirect buffer.
// Optional macro PC_ALIGN_TRAP_EN: misaligned redirects trap to TRAP_VEC and raise sticky misalign_err.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned       STEP      = DEFAULT_STEP,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000)
`ifdef PC_ALIGN_TRAP_EN
  ,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0080)
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              pc_valid
`ifdef PC_ALIGN_TRAP_EN
  ,
  output logic              misalign_err
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(STEP, ADDR_W));

  pc_state_t         state;
  pc_state_t         state_next;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pend_next;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_load;
  logic              load_redirect;
  logic [ADDR_W-1:0] redirect_sel;
  logic [ADDR_W-1:0] redirect_fixed;
  logic              live_valid;
  logic [ADDR_W-1:0] live_target;

  pc_step_adder #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_step_adder (
    .pc          (pc),
    .pc_next_seq (pc_next_seq)
  );

  // Jump outranks branch when both arrive together.
  assign live_valid  = jump_valid | branch_valid;
  assign live_target = jump_valid ? jump_target : branch_target;

  // Next-state, load-select and pending-buffer update.
  always_comb begin
    state_next    = state;
    pend_next     = pend_target;
    pc_load       = 1'b0;
    load_redirect = 1'b0;
    redirect_sel  = live_target;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN, HOLD: begin
        if (!stall) begin
          pc_load       = 1'b1;
          load_redirect = live_valid;
          state_next    = RUN;
        end else if (live_valid) begin
          pend_next  = live_target;
          state_next = HOLD_PEND;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD_PEND: begin
        if (!stall) begin
          pc_load       = 1'b1;
          load_redirect = 1'b1;
          redirect_sel  = live_valid ? live_target : pend_target;
          pend_next     = '0;
          state_next    = RUN;
        end else if (live_valid) begin
          pend_next = live_target;
        end else begin
          pend_next = pend_target;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

`ifdef PC_ALIGN_TRAP_EN
  logic misaligned;
  assign misaligned     = |(redirect_sel & ~ALIGN_MASK);
  assign redirect_fixed = misaligned ? TRAP_VEC : redirect_sel;

  // Sticky alignment error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_err | (pc_load & load_redirect & misaligned);
    end
  end
`else
  assign redirect_fixed = redirect_sel & ALIGN_MASK;
`endif

  assign pc_d = pc_load ? (load_redirect ? redirect_fixed : pc_next_seq) : pc;

  // State, pc, valid flag and pending buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      pc_valid    <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_d;
      pc_valid    <= (state_next == RUN);
      pend_target <= pend_next;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered, parametrised program-counter sequencer for the MIPS fetch stage. It holds the current fetch address and advances it by a configurable step each cycle (4 on the 32-bit core). It accepts jump and branch redirects, freezes on stall, and buffers a redirect that arrives while stalled so it is never lost. It sits between the control/branch-resolution logic and the instruction memory address port.

## Interface
- ADDR_W, 32, address width in bits
- STEP, 4, increment per advance; power of two, at most 2^(ADDR_W-1)
- RESET_VEC, 32'h0000_0000, pc value after reset
- TRAP_VEC, 32'h0000_0080, pc loaded on misaligned redirect (only with PC_ALIGN_TRAP_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- stall  in  1  hold pc this cycle
- jump_valid  in  1  jump redirect request
- jump_target  in  ADDR_W  jump destination
- branch_valid  in  1  taken-branch redirect request
- branch_target  in  ADDR_W  branch destination
- pc  out  ADDR_W  current fetch address (registered)
- pc_next_seq  out  ADDR_W  pc + STEP, combinational from pc
- pc_valid  out  1  pc is a valid fetch address this cycle
- misalign_err  out  1  sticky error flag; exists only with PC_ALIGN_TRAP_EN

## Operation
- Reset values: pc = RESET_VEC, pc_valid = 0, pending buffer empty, misalign_err = 0, state BOOT.
- States:
  - BOOT: one cycle after reset release with pc_valid = 0, then RUN. Stall is ignored in BOOT.
  - RUN: pc_valid = 1.
    - stall = 0: pc loads the selected source.
    - stall = 1 with no redirect: go to HOLD.
    - stall = 1 with a redirect: capture it in the pending buffer and go to HOLD_PEND.
  - HOLD: pc frozen, pc_valid = 0.
    - stall = 1 with a redirect: go to HOLD_PEND.
    - stall = 0: load the selected source and go to RUN.
  - HOLD_PEND: pc frozen, pc_valid = 0.
    - A new redirect overwrites the pending entry (latest wins).
    - stall = 0: load the live redirect if present, otherwise the pending target. Clear pending and go to RUN.
- Source priority, highest first: live jump_valid, live branch_valid, pending target, pc_next_seq.
  - jump_valid and branch_valid both high: jump wins, branch is dropped.
- Arithmetic: pc_next_seq = (pc + STEP) mod 2^ADDR_W. Carry is discarded and wrap-around is silent (all-ones page wraps to 0).
- Redirect targets are loaded unmodified unless the configuration below says otherwise.

## Timing
- Redirect presented in cycle N with stall = 0: pc equals the target after edge N+1, so latency is 1 cycle.
- Sequential advance: pc changes every non-stalled RUN cycle.
- Redirect presented during a stall: applied on the first edge at which stall = 0.
- Async rst asserted mid-stall or mid-redirect:
  - Immediately forces the reset values and drops any pending entry.
  - Deassertion is sampled synchronously; the BOOT cycle follows.
- pc_next_seq is a pure function of pc and has no added latency.

## Configuration
- PC_ALIGN_TRAP_EN defined:
  - A redirect target whose low log2(STEP) bits are nonzero loads TRAP_VEC instead of the target.
  - It sets misalign_err, which stays set until rst.
  - The check applies to both live and pending redirects at load time.
- PC_ALIGN_TRAP_EN undefined:
  - The low log2(STEP) bits of every redirect target are masked to zero before loading.
  - No misalign_err port exists.

## Structure
- Shared package pc_pkg holds:
  - the state enum pc_state_t (BOOT, RUN, HOLD, HOLD_PEND);
  - default ADDR_W and STEP constants;
  - an align_mask function of STEP and ADDR_W.
- Sub-module pc_step_adder (ADDR_W, STEP): parametrised incrementer producing pc_next_seq with carry dropped. It replaces the fixed 32-bit +4 adder used in earlier fetch logic.

## Test plan
- Reset then run, stall = 0: pc_valid = 0 for one cycle, then pc = 0x0, 0x4, 0x8, 0xC on successive edges.
- At pc = 0x10, assert jump_valid with 0x400 and branch_valid with 0x200 together: next pc = 0x400, then 0x404.
- Stall at pc = 0x20; during the stall assert branch 0x300, then a later branch 0x500; release stall: pc stays 0x20, then goes to 0x500, then 0x504.
- ADDR_W = 32, pc at 0xFFFF_FFFC, no redirect: next pc = 0x0000_0000 and pc_valid stays 1.
- Jump to 0x102:
  - with PC_ALIGN_TRAP_EN: pc = 0x80 and misalign_err = 1 until rst;
  - without it: pc = 0x100.
- Assert rst asynchronously mid-HOLD_PEND: pc = 0x0 and pc_valid = 0 immediately. After release, the pending target is never loaded.
